axi4_mem_subordinate: RTL and testbench

AXI4 subordinate that terminates the 128-bit DRAM-side manager port of the BlackParrot AXI wrapper with an on-chip synchronous-RAM memory. It is used for FPGA bring-up without a DDR controller and as the memory endpoint in simulation. It serves INCR and FIXED bursts and handles one transaction at a time. It arbitrates round-robin between reads and writes and flags out-of-range addresses and protocol errors in the response.

---
 rtl/axi4_mem_subordinate.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_axi4_mem_subordinate.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_mem_subordinate.sv
// AXI4 subordinate backed by an on-chip synchronous RAM.
// Serves INCR and FIXED bursts, one transaction at a time, with
// round-robin arbitration between the read and write address channels.
// Out-of-range beats answer DECERR; WRAP/reserved bursts and wlast
// mismatches answer SLVERR. The reset input is expected to deassert
// synchronously to s_axi_aclk (released by the system reset generator).
module axi4_mem_subordinate #(
  parameter int unsigned           ADDR_WIDTH = 64,
  parameter int unsigned           DATA_WIDTH = 128,
  parameter int unsigned           ID_WIDTH   = 4,
  parameter int unsigned           MEM_ELS    = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 64'h0
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  // Write address channel
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic [3:0]              s_axi_awregion,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  // Write data channel
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  // Write response channel
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  // Read address channel
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic [3:0]              s_axi_arregion,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  // Read data channel
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(MEM_ELS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_WR_RESP
  } state_e;

  typedef enum logic {
    GRANT_READ,
    GRANT_WRITE
  } grant_e;

  // Storage
  logic [DATA_WIDTH-1:0] mem_q [MEM_ELS];

  // Transaction context
  state_e                state_q;
  grant_e                last_grant_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [7:0]            beat_q;
  logic                  overrun_q;
  logic                  dec_err_q;
  logic                  slv_err_q;

  // Registered channel outputs
  logic                  awready_q;
  logic                  arready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic [ID_WIDTH-1:0]   bid_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [1:0]            rresp_q;
  logic                  rlast_q;

  // Address helpers
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [7:0]            rd_beat;
  logic                  rd_ok;
  logic [IDX_W-1:0]      rd_idx;
  logic [1:0]            rd_resp;
  logic                  rd_fire;
  logic                  r_hs;
  logic                  w_hs;
  logic                  wr_ok;
  logic [IDX_W-1:0]      wr_idx;
  logic                  wr_at_len;
  logic                  mem_we;
  logic                  dec_err_d;
  logic                  slv_err_d;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = (a - BASE_ADDR) >> OFF_W;
    return (a >= BASE_ADDR) && (off < ADDR_WIDTH'(MEM_ELS));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = (a - BASE_ADDR) >> OFF_W;
    return off[IDX_W-1:0];
  endfunction

  // Address of the following beat: FIXED holds, all other burst types step by the beat size.
  always_comb begin
    // NOTE: assign a default before any condition so no path can infer a latch.
    next_addr = addr_q;
    if (burst_q != BURST_FIXED) begin
      next_addr = addr_q + (ADDR_WIDTH'(1) << size_q);
    end
  end

  // Read side: in RD_DATA the RAM is already fetching the beat after the one on the bus.
  assign r_hs    = rvalid_q & s_axi_rready;
  assign rd_addr = (state_q == ST_RD_DATA) ? next_addr : addr_q;
  assign rd_beat = (state_q == ST_RD_DATA) ? beat_q + 8'd1 : beat_q;
  assign rd_ok   = in_range(rd_addr);
  assign rd_idx  = word_idx(rd_addr);
  assign rd_fire = (state_q == ST_RD_ISSUE) | ((state_q == ST_RD_DATA) & r_hs & ~rlast_q);
  assign rd_resp = !rd_ok      ? RESP_DECERR :
                   burst_q[1]  ? RESP_SLVERR : RESP_OKAY;

  // Write side: beats after an overrun are discarded, the error is already recorded.
  assign w_hs      = wready_q & s_axi_wvalid;
  assign wr_ok     = in_range(addr_q);
  assign wr_idx    = word_idx(addr_q);
  assign wr_at_len = (beat_q == len_q) & ~overrun_q;
  assign mem_we    = w_hs & ~overrun_q & wr_ok;
  assign dec_err_d = dec_err_q | (w_hs & ~overrun_q & ~wr_ok);
  assign slv_err_d = slv_err_q | (w_hs & (s_axi_wlast != wr_at_len));

  // Transaction FSM with registered channel outputs.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_WRITE;
      addr_q       <= '0;
      id_q         <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      beat_q       <= '0;
      overrun_q    <= 1'b0;
      dec_err_q    <= 1'b0;
      slv_err_q    <= 1'b0;
      awready_q    <= 1'b0;
      arready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bid_q        <= '0;
      bresp_q      <= RESP_OKAY;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      rid_q        <= '0;
      rresp_q      <= RESP_OKAY;
      rlast_q      <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      if (rd_fire) begin
        rdata_q <= rd_ok ? mem_q[rd_idx] : '0;
        rresp_q <= rd_resp;
        rlast_q <= (rd_beat == len_q);
        rid_q   <= id_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (arready_q) begin
            arready_q <= 1'b0;
            if (s_axi_arvalid) begin
              addr_q  <= s_axi_araddr;
              id_q    <= s_axi_arid;
              len_q   <= s_axi_arlen;
              size_q  <= s_axi_arsize;
              burst_q <= s_axi_arburst;
              beat_q  <= '0;
              state_q <= ST_RD_ISSUE;
            end
          end else if (awready_q) begin
            awready_q <= 1'b0;
            if (s_axi_awvalid) begin
              addr_q    <= s_axi_awaddr;
              id_q      <= s_axi_awid;
              len_q     <= s_axi_awlen;
              size_q    <= s_axi_awsize;
              burst_q   <= s_axi_awburst;
              beat_q    <= '0;
              overrun_q <= 1'b0;
              dec_err_q <= 1'b0;
              slv_err_q <= s_axi_awburst[1];
              wready_q  <= 1'b1;
              state_q   <= ST_WR_DATA;
            end
          end else if (s_axi_arvalid && s_axi_awvalid) begin
            if (last_grant_q == GRANT_WRITE) arready_q <= 1'b1;
            else                             awready_q <= 1'b1;
          end else if (s_axi_arvalid) begin
            arready_q <= 1'b1;
          end else if (s_axi_awvalid) begin
            awready_q <= 1'b1;
          end
        end

        ST_RD_ISSUE: begin
          rvalid_q <= 1'b1;
          state_q  <= ST_RD_DATA;
        end

        ST_RD_DATA: begin
          if (r_hs) begin
            if (rlast_q) begin
              rvalid_q     <= 1'b0;
              last_grant_q <= GRANT_READ;
              state_q      <= ST_IDLE;
            end else begin
              addr_q <= next_addr;
              beat_q <= beat_q + 8'd1;
            end
          end
        end

        ST_WR_DATA: begin
          if (w_hs) begin
            dec_err_q <= dec_err_d;
            slv_err_q <= slv_err_d;
            if (!overrun_q) begin
              addr_q <= next_addr;
              beat_q <= beat_q + 8'd1;
            end
            if (wr_at_len && !s_axi_wlast) overrun_q <= 1'b1;
            if (s_axi_wlast) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= id_q;
              bresp_q  <= dec_err_d ? RESP_DECERR :
                          slv_err_d ? RESP_SLVERR : RESP_OKAY;
              state_q  <= ST_WR_RESP;
            end
          end
        end

        ST_WR_RESP: begin
          if (s_axi_bready) begin
            bvalid_q     <= 1'b0;
            dec_err_q    <= 1'b0;
            slv_err_q    <= 1'b0;
            last_grant_q <= GRANT_WRITE;
            state_q      <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Byte-lane RAM write port; out-of-range and discarded beats never enable it.
  always_ff @(posedge s_axi_aclk) begin
    // NOTE: the RAM array has no reset so it maps onto block RAM; contents survive reset.
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem_q[wr_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_arready = arready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;

  // Sideband attributes carry no meaning for a flat RAM.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion,
                           s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion};

endmodule

// File: tb/tb_axi4_mem_subordinate.sv
// Scoreboard bench for axi4_mem_subordinate: drivers push expected R/B
// responses into queues, a negedge monitor pops and compares them.
module tb_axi4_mem_subordinate;

  typedef struct {
    logic [127:0] data;
    logic [1:0]   resp;
    logic         last;
    logic [3:0]   id;
  } r_exp_t;

  typedef struct {
    logic [1:0] resp;
    logic [3:0] id;
  } b_exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [63:0]  awaddr = '0, araddr = '0;
  logic [3:0]   awid = '0, arid = '0;
  logic [7:0]   awlen = '0, arlen = '0;
  logic [2:0]   awsize = '0, arsize = '0;
  logic [1:0]   awburst = '0, arburst = '0;
  logic         awvalid = 1'b0, arvalid = 1'b0;
  logic [127:0] wdata = '0;
  logic [15:0]  wstrb = '0;
  logic         wlast = 1'b0, wvalid = 1'b0, bready = 1'b0, rready = 1'b0;
  logic         awready, arready, wready, bvalid, rvalid, rlast;
  logic [3:0]   bid, rid;
  logic [1:0]   bresp, rresp;
  logic [127:0] rdata;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ar_cyc = 0;
  bit lat_pending = 0;
  int r_beats = 0;
  int rlast_seen = 0;
  r_exp_t exp_r[$];
  b_exp_t exp_b[$];
  int grant_log[$];
  logic [127:0] wbeats [16];
  logic [15:0]  wstrbs [16];

  axi4_mem_subordinate dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awid(awid), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'h0), .s_axi_awprot(3'h0),
    .s_axi_awqos(4'h0), .s_axi_awregion(4'h0), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arid(arid), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'h0), .s_axi_arprot(3'h0),
    .s_axi_arqos(4'h0), .s_axi_arregion(4'h0), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rid(rid), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out or unexpected", name);
  endtask

  function automatic logic [127:0] pat(input int i);
    return {32'h1111_0000 + 32'(i), 32'h2222_0000 + 32'(i), 32'h3333_0000 + 32'(i), 32'h4444_0000 + 32'(i)};
  endfunction

  function automatic logic sig_val(input int sel);
    case (sel)
      0:       return awready;
      1:       return arready;
      2:       return wready;
      3:       return bvalid;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sig_val(sel) && n < 200);
    if (!sig_val(sel)) fail_now(name);
  endtask

  task automatic push_r(input logic [127:0] d, input logic [1:0] rs, input logic l, input logic [3:0] i);
    exp_r.push_back('{data: d, resp: rs, last: l, id: i});
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input int nbeats, input int last_at,
                          input logic [1:0] exp_resp);
    exp_b.push_back('{resp: exp_resp, id: id});
    awaddr = addr; awid = id; awlen = len; awsize = 3'd4; awburst = burst; awvalid = 1'b1;
    wait_for(0, "aw_handshake");
    @(posedge clk); #1 awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wdata = wbeats[i]; wstrb = wstrbs[i]; wlast = (i == last_at); wvalid = 1'b1;
      wait_for(2, "w_handshake");
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    wait_for(3, "b_handshake");
    @(posedge clk); #1 bready = 1'b0;
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst, input bit toggle);
    int start = rlast_seen;
    int n = 0;
    araddr = addr; arid = id; arlen = len; arsize = 3'd4; arburst = burst; arvalid = 1'b1;
    wait_for(1, "ar_handshake");
    @(posedge clk); #1 arvalid = 1'b0;
    rready = !toggle;
    while (rlast_seen == start && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (toggle) rready = !rready;
    end
    rready = 1'b0;
    if (rlast_seen == start) fail_now("r_burst_end");
  endtask

  task automatic one_beat(input logic [127:0] d, input logic [15:0] s);
    wbeats[0] = d;
    wstrbs[0] = s;
  endtask

  // Monitor: compares every R/B handshake (and stalled R beat) against the queue heads.
  initial forever begin
    r_exp_t e;
    b_exp_t eb;
    @(negedge clk);
    if (arvalid && arready) begin
      grant_log.push_back(0);
      ar_cyc = cyc;
      lat_pending = 1;
    end
    if (awvalid && awready) grant_log.push_back(1);
    if (rvalid && lat_pending) begin
      check("rd_latency", 128'(cyc - ar_cyc), 128'd2);
      lat_pending = 0;
    end
    if (rvalid) begin
      if (exp_r.size() == 0) begin
        fail_now("r_unexpected_beat");
      end else if (!rready) begin
        e = exp_r[0];
        check("r_stall_data", rdata, e.data);
        check("r_stall_last", 128'(rlast), 128'(e.last));
      end else begin
        e = exp_r.pop_front();
        check("r_data", rdata, e.data);
        check("r_resp", 128'(rresp), 128'(e.resp));
        check("r_last", 128'(rlast), 128'(e.last));
        check("r_id", 128'(rid), 128'(e.id));
        r_beats++;
        if (rlast) rlast_seen++;
      end
    end
    if (bvalid && bready) begin
      if (exp_b.size() == 0) begin
        fail_now("b_unexpected");
      end else begin
        eb = exp_b.pop_front();
        check("b_resp", 128'(bresp), 128'(eb.resp));
        check("b_id", 128'(bid), 128'(eb.id));
      end
    end
  end

  initial begin
    int b0;
    int n;
    logic [127:0] d1;
    d1 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 128'(awready), 128'd0);
    check("rst_arready", 128'(arready), 128'd0);
    check("rst_wready", 128'(wready), 128'd0);
    check("rst_bvalid", 128'(bvalid), 128'd0);
    check("rst_rvalid", 128'(rvalid), 128'd0);
    check("rst_rdata", rdata, 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single-beat write then read
    one_beat(d1, 16'hFFFF);
    do_write(64'h40, 4'd1, 8'd0, 2'b01, 1, 0, 2'b00);
    push_r(d1, 2'b00, 1'b1, 4'd2);
    do_read(64'h40, 4'd2, 8'd0, 2'b01, 1'b0);

    // 2: 8-beat INCR burst, read back streaming and with rready toggling
    for (int i = 0; i < 8; i++) begin
      wbeats[i] = pat(i);
      wstrbs[i] = 16'hFFFF;
    end
    do_write(64'h100, 4'd4, 8'd7, 2'b01, 8, 7, 2'b00);
    for (int i = 0; i < 8; i++) push_r(pat(i), 2'b00, i == 7, 4'd6);
    do_read(64'h100, 4'd6, 8'd7, 2'b01, 1'b0);
    for (int i = 0; i < 8; i++) push_r(pat(i), 2'b00, i == 7, 4'd7);
    do_read(64'h100, 4'd7, 8'd7, 2'b01, 1'b1);

    // FIXED burst returns the same word every beat
    push_r(pat(0), 2'b00, 1'b0, 4'd8);
    push_r(pat(0), 2'b00, 1'b1, 4'd8);
    do_read(64'h100, 4'd8, 8'd1, 2'b00, 1'b0);

    // 3: partial strobe over an existing word
    one_beat({16{8'hAA}}, 16'hFFFF);
    do_write(64'h80, 4'd1, 8'd0, 2'b01, 1, 0, 2'b00);
    one_beat({16{8'hFF}}, 16'h00FF);
    do_write(64'h80, 4'd1, 8'd0, 2'b01, 1, 0, 2'b00);
    push_r(128'hAAAAAAAA_AAAAAAAA_FFFFFFFF_FFFFFFFF, 2'b00, 1'b1, 4'd9);
    do_read(64'h80, 4'd9, 8'd0, 2'b01, 1'b0);

    // 4: out of range at the top of memory
    one_beat({16{8'h5A}}, 16'hFFFF);
    do_write(64'hFFF0, 4'd2, 8'd0, 2'b01, 1, 0, 2'b00);
    one_beat({8{16'h0F0F}}, 16'hFFFF);
    do_write(64'h0, 4'd2, 8'd0, 2'b01, 1, 0, 2'b00);
    push_r({16{8'h5A}}, 2'b00, 1'b0, 4'd3);
    push_r(128'd0, 2'b11, 1'b1, 4'd3);
    do_read(64'hFFF0, 4'd3, 8'd1, 2'b01, 1'b0);
    one_beat({16{8'hFF}}, 16'hFFFF);
    do_write(64'h10000, 4'd2, 8'd0, 2'b01, 1, 0, 2'b11);
    push_r({8{16'h0F0F}}, 2'b00, 1'b1, 4'd4);
    do_read(64'h0, 4'd4, 8'd0, 2'b01, 1'b0);

    // 6a: awlen=3 but wlast on beat 1 -> SLVERR, both beats stored, back to IDLE
    wbeats[0] = pat(10); wbeats[1] = pat(11);
    wstrbs[0] = 16'hFFFF; wstrbs[1] = 16'hFFFF;
    do_write(64'h300, 4'd5, 8'd3, 2'b01, 2, 1, 2'b10);
    push_r(pat(10), 2'b00, 1'b0, 4'd5);
    push_r(pat(11), 2'b00, 1'b1, 4'd5);
    do_read(64'h300, 4'd5, 8'd1, 2'b01, 1'b0);

    // Beat beyond len without wlast is discarded and flagged
    wbeats[0] = pat(20); wbeats[1] = pat(21);
    do_write(64'h400, 4'd6, 8'd0, 2'b01, 2, 1, 2'b10);
    push_r(pat(20), 2'b00, 1'b1, 4'd6);
    do_read(64'h400, 4'd6, 8'd0, 2'b01, 1'b0);

    // 6b: reset in the middle of a read burst
    for (int i = 0; i < 8; i++) push_r(pat(i), 2'b00, i == 7, 4'd1);
    b0 = r_beats;
    araddr = 64'h100; arid = 4'd1; arlen = 8'd7; arsize = 3'd4; arburst = 2'b01; arvalid = 1'b1;
    wait_for(1, "ar_handshake_rst");
    @(posedge clk); #1 arvalid = 1'b0;
    rready = 1'b1;
    n = 0;
    while (r_beats < b0 + 3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (r_beats < b0 + 3) fail_now("mid_burst_beats");
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_rvalid", 128'(rvalid), 128'd0);
    check("rst_mid_rlast", 128'(rlast), 128'd0);
    check("rst_mid_rdata", rdata, 128'd0);
    exp_r.delete();
    rready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 5: simultaneous AR/AW after reset -> read first, ids echoed
    grant_log.delete();
    wbeats[0] = pat(30); wstrbs[0] = 16'hFFFF;
    push_r(d1, 2'b00, 1'b1, 4'd5);
    fork
      do_read(64'h40, 4'd5, 8'd0, 2'b01, 1'b0);
      do_write(64'h200, 4'd3, 8'd0, 2'b01, 1, 0, 2'b00);
    join
    check("grant_count", 128'(grant_log.size()), 128'd2);
    if (grant_log.size() == 2) begin
      check("grant_first_read", 128'(grant_log[0]), 128'd0);
      check("grant_second_write", 128'(grant_log[1]), 128'd1);
    end
    push_r(pat(30), 2'b00, 1'b1, 4'd7);
    do_read(64'h200, 4'd7, 8'd0, 2'b01, 1'b0);

    repeat (3) @(posedge clk);
    check("r_queue_empty", 128'(exp_r.size()), 128'd0);
    check("b_queue_empty", 128'(exp_b.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
